// File: rtl/mul_pkg.sv
// mul_pkg: op encodings, Booth digit type and sizing helpers
// shared by booth_mul_pipe and its CSA tree.
package mul_pkg;

   localparam logic [1:0] MUL_UU = 2'b00;
   localparam logic [1:0] MUL_SS = 2'b01;
   localparam logic [1:0] MUL_SU = 2'b10;

   typedef enum logic [4:0] {
      B_ZERO = 5'b00001,
      B_POS1 = 5'b00010,
      B_POS2 = 5'b00100,
      B_NEG1 = 5'b01000,
      B_NEG2 = 5'b10000
   } booth_t;

   function automatic int npp(input int width);
      return width / 2 + 1;
   endfunction

   // {b[i+1], b[i], b[i-1]} -> radix-4 digit
   function automatic booth_t booth_enc(input logic [2:0] i_t);
      booth_t d;
      d = B_ZERO;
      case (i_t)
         3'b001, 3'b010: d = B_POS1;
         3'b011:         d = B_POS2;
         3'b100:         d = B_NEG2;
         3'b101, 3'b110: d = B_NEG1;
         default:        d = B_ZERO;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/csa_3to2.sv
// csa_3to2: N-bit 3:2 carry-save adder, carry pre-shifted
// into its weight so that s + c == a + b + c.
module csa_3to2 #(
   parameter int N = 64
) (
   input  logic [N-1:0] i_a,
   input  logic [N-1:0] i_b,
   input  logic [N-1:0] i_c,
   output logic [N-1:0] o_s,
   output logic [N-1:0] o_c
);

   logic [N-1:0] w_maj;

   assign o_s   = i_a ^ i_b ^ i_c;
   assign w_maj = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
   assign o_c   = w_maj << 1;

endmodule

// File: rtl/booth_mul_pipe.sv
// booth_mul_pipe: 3-stage radix-4 Booth / CSA-tree multiplier.
// Optional MUL_FLUSH_EN adds a flush input cancelling in-flight ops.
module booth_mul_pipe
   import mul_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int TAG_W = 5
) (
   input  logic               mul_clk,
   input  logic               resetn,
`ifdef MUL_FLUSH_EN
   input  logic               flush,
`endif
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [1:0]         in_op,
   input  logic [WIDTH-1:0]   in_a,
   input  logic [WIDTH-1:0]   in_b,
   input  logic [TAG_W-1:0]   in_tag,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] out_result,
   output logic [TAG_W-1:0]   out_tag
);

   localparam int P    = 2 * WIDTH;
   localparam int NPP  = npp(WIDTH);
   localparam int NCSA = NPP - 2;

   logic w_flush;
`ifdef MUL_FLUSH_EN
   assign w_flush = flush;
`else
   assign w_flush = 1'b0;
`endif

   logic r_s1_v, r_s2_v, r_s3_v;
   logic w_s1_adv, w_s2_adv, w_s3_adv, w_acc;

   assign w_s3_adv = out_ready | ~r_s3_v;
   assign w_s2_adv = ~r_s3_v | w_s3_adv;
   assign w_s1_adv = ~r_s2_v | w_s2_adv;
   assign in_ready = (~r_s1_v | w_s1_adv) & ~w_flush;
   assign w_acc    = in_valid & in_ready;

   logic             w_a_sgn, w_b_sgn;
   logic [P-1:0]     w_ax;
   logic [WIDTH+2:0] w_bx;
   booth_t           w_dig [NPP];
   logic [P-1:0]     w_pp  [NPP];

   always_comb begin
      w_a_sgn = 1'b0;
      w_b_sgn = 1'b0;
      unique case (in_op)
         MUL_SS: begin
            w_a_sgn = 1'b1;
            w_b_sgn = 1'b1;
         end
         MUL_SU:  w_a_sgn = 1'b1;
         MUL_UU:  ;
         default: ;
      endcase
   end

   // B gets a zero below bit 0 and two extension bits on top
   assign w_ax = {{WIDTH{w_a_sgn & in_a[WIDTH-1]}}, in_a};
   assign w_bx = {{2{w_b_sgn & in_b[WIDTH-1]}}, in_b, 1'b0};

   always_comb begin
      for (int i = 0; i < NPP; i++) begin
         w_dig[i] = booth_enc(w_bx[2*i +: 3]);
         unique case (1'b1)
            w_dig[i][1]: w_pp[i] = w_ax;
            w_dig[i][2]: w_pp[i] = w_ax << 1;
            w_dig[i][3]: w_pp[i] = -w_ax;
            w_dig[i][4]: w_pp[i] = -(w_ax << 1);
            default:     w_pp[i] = '0;
         endcase
         w_pp[i] = w_pp[i] << (2 * i);
      end
   end

   logic [P-1:0]     r_s1_pp [NPP];
   logic [TAG_W-1:0] r_s1_tag;
   logic [P-1:0]     r_s2_sum, r_s2_car;
   logic [TAG_W-1:0] r_s2_tag;
   logic [P-1:0]     r_out_result;
   logic [TAG_W-1:0] r_out_tag;
   logic [P-1:0]     w_csa_s, w_csa_c;

   // rows 0..NPP-1 are partial products; CSA j eats rows
   // 3j..3j+2 and emits rows NPP+2j (sum) and NPP+2j+1 (carry)
   for (genvar j = 0; j < NCSA; j++) begin : g_csa
      logic [P-1:0] w_in [3];
      logic [P-1:0] w_s, w_c;
      for (genvar k = 0; k < 3; k++) begin : g_in
         localparam int R = 3 * j + k;
         if (R < NPP) begin : g_pp
            assign w_in[k] = r_s1_pp[R];
         end else if (((R - NPP) % 2) == 0) begin : g_s
            localparam int K = (R - NPP) / 2;
            assign w_in[k] = g_csa[K].w_s;
         end else begin : g_c
            localparam int K = (R - NPP) / 2;
            assign w_in[k] = g_csa[K].w_c;
         end
      end
      csa_3to2 #(.N(P)) u_csa (
         .i_a (w_in[0]),
         .i_b (w_in[1]),
         .i_c (w_in[2]),
         .o_s (w_s),
         .o_c (w_c)
      );
   end

   assign w_csa_s = g_csa[NCSA-1].w_s;
   assign w_csa_c = g_csa[NCSA-1].w_c;

   always_ff @(posedge mul_clk) begin
      if (!resetn) begin
         r_s1_v       <= 1'b0;
         r_s2_v       <= 1'b0;
         r_s3_v       <= 1'b0;
         r_out_result <= '0;
         r_out_tag    <= '0;
      end else begin
         if (w_flush) begin
            r_s1_v <= 1'b0;
            r_s2_v <= 1'b0;
            r_s3_v <= 1'b0;
         end else begin
            if (in_ready) r_s1_v <= in_valid;
            if (w_s1_adv) r_s2_v <= r_s1_v;
            if (w_s2_adv) r_s3_v <= r_s2_v;
         end
         if (w_s2_adv & r_s2_v) begin
            r_out_result <= r_s2_sum + r_s2_car;
            r_out_tag    <= r_s2_tag;
         end
      end
   end

   always_ff @(posedge mul_clk) begin
      if (w_acc) begin
         r_s1_pp  <= w_pp;
         r_s1_tag <= in_tag;
      end
      if (w_s1_adv & r_s1_v) begin
         r_s2_sum <= w_csa_s;
         r_s2_car <= w_csa_c;
         r_s2_tag <= r_s1_tag;
      end
   end

   assign out_valid  = r_s3_v;
   assign out_result = r_out_result;
   assign out_tag    = r_out_tag;

endmodule
